irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h8000_0000, kernel-space base of the handler vector table.
REQ-002 Parameter TX_PRIO_LOW, default 1, places UART-send below UART-receive when set.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pc  in  32  PC of the instruction currently in execute.
REQ-006 cpu_stall  in  1  high = current instruction not retiring this cycle.
REQ-007 timer_irq  in  1  level request from timer (TCON status bit).
REQ-008 uart_rx_evt  in  1  one-cycle pulse, receive byte ready.
REQ-009 uart_tx_evt  in  1  one-cycle pulse, transmit complete.
REQ-010 exc_req  in  1  undefined-instruction decode flag for current instruction.
REQ-011 eret  in  1  one-cycle pulse, "jr $26" retiring in kernel mode.
REQ-012 take  out  1  one-cycle pulse: PC mux selects vector_pc, regfile writes $26.
REQ-013 vector_pc  out  32  handler address, valid while take=1.
REQ-014 epc_data  out  32  value written to $26, valid while take=1.
REQ-015 cause  out  3  0=none,1=timer,2=exception,3=uart_tx,4=uart_rx; held through SERVICE.
REQ-016 in_service  out  1  high from take through eret.
REQ-017 nest_err  out  1  sticky: exc_req seen in kernel mode.

Function
REQ-018 States: IDLE, SERVICE; take is a Mealy pulse from IDLE.
REQ-019 Pending bits rx_pend, tx_pend set on their pulses in any state; timer uses timer_irq level directly, no latch.
REQ-020 Set and clear of the same pending bit in one cycle: set wins (bit stays 1).
REQ-021 Take condition: state IDLE, pc[31]=0, cpu_stall=0, and any of exc_req, timer_irq, rx_pend, tx_pend.
REQ-022 Priority: exc_req > timer_irq > rx_pend > tx_pend (TX_PRIO_LOW=1); TX_PRIO_LOW=0 swaps rx/tx.
REQ-023 vector_pc = VEC_BASE | {cause_word,2'b00}; words: timer 1, exception 2, uart_tx 3, uart_rx 4 (0x8000_0004/08/0C/10).
REQ-024 epc_data = pc for interrupts (instruction replayed); pc+4 for exception (instruction skipped); 32-bit wrap on pc+4.
REQ-025 On take: state->SERVICE, cause latched, serviced pending bit cleared same edge.
REQ-026 In SERVICE: no take; new events only accumulate pending.
REQ-027 eret in SERVICE: state->IDLE, cause->0 on same edge; earliest next take is the following cycle.
REQ-028 eret in IDLE: ignored.
REQ-029 exc_req with pc[31]=1 or state SERVICE: not taken, nest_err set; cleared only by reset.
REQ-030 cpu_stall=1 defers take; pending state unchanged.

Reset
REQ-031 reset asserted: state IDLE, rx_pend=tx_pend=0, cause=0, in_service=0, nest_err=0, take=0 immediately (asynchronous).
REQ-032 reset during SERVICE abandons the handler; no eret required afterward.

Structure
REQ-033 Shared package: cause code constants, vector word offsets, VEC_BASE default, state encoding.
REQ-034 One sub-module irq_prio_enc: combinational 4-input fixed-priority encoder producing cause and grant one-hot.

Verification
REQ-035 uart_rx_evt pulse, pc=0x0000_0100, no stall -> take=1 same cycle, vector_pc=0x8000_0010, epc_data=0x0000_0100, cause=4.
REQ-036 exc_req and timer_irq together at pc=0x0000_0200 -> vector_pc=0x8000_0008, epc_data=0x0000_0204, cause=2; timer taken the cycle after eret.
REQ-037 uart_tx_evt twice during SERVICE, then eret -> exactly one take with cause=3 next cycle, tx_pend then 0.
REQ-038 rx and tx pulses in same cycle, IDLE -> rx serviced first (0x8000_0010); tx after eret (0x8000_000C).
REQ-039 exc_req at pc=0x8000_0040 -> no take, nest_err=1 until reset.
REQ-040 reset asserted mid-SERVICE with rx_pend=1 -> all outputs 0 immediately, no take after release without new event.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: cause codes, vector word
// offsets, request indices and FSM state encoding.
package irq_ctrl_pkg;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_TIMER = 3'd1;
  localparam logic [2:0] CAUSE_EXC   = 3'd2;
  localparam logic [2:0] CAUSE_TX    = 3'd3;
  localparam logic [2:0] CAUSE_RX    = 3'd4;

  localparam logic [29:0] VW_TIMER = 30'd1;
  localparam logic [29:0] VW_EXC   = 30'd2;
  localparam logic [29:0] VW_TX    = 30'd3;
  localparam logic [29:0] VW_RX    = 30'd4;

  // Bit positions of the request / grant vectors.
  localparam int IDX_TX    = 0;
  localparam int IDX_RX    = 1;
  localparam int IDX_TIMER = 2;
  localparam int IDX_EXC   = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

  function automatic logic [29:0] vec_word(input logic [2:0] c);
    case (c)
      CAUSE_TIMER: vec_word = VW_TIMER;
      CAUSE_EXC:   vec_word = VW_EXC;
      CAUSE_TX:    vec_word = VW_TX;
      CAUSE_RX:    vec_word = VW_RX;
      default:     vec_word = 30'd0;
    endcase
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: exception > timer > rx > tx, with rx/tx order
// swappable by TX_PRIO_LOW. Produces the cause code and a one-hot grant.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int TX_PRIO_LOW = 1
) (
  input  logic [3:0] req_i,
  output logic [2:0] cause_o,
  output logic [3:0] grant_o
);

  always_comb begin
    cause_o = CAUSE_NONE;
    grant_o = 4'b0000;
    if (req_i[IDX_EXC]) begin
      cause_o = CAUSE_EXC;
      grant_o[IDX_EXC] = 1'b1;
    end else if (req_i[IDX_TIMER]) begin
      cause_o = CAUSE_TIMER;
      grant_o[IDX_TIMER] = 1'b1;
    end else if (TX_PRIO_LOW != 0) begin
      if (req_i[IDX_RX]) begin
        cause_o = CAUSE_RX;
        grant_o[IDX_RX] = 1'b1;
      end else if (req_i[IDX_TX]) begin
        cause_o = CAUSE_TX;
        grant_o[IDX_TX] = 1'b1;
      end
    end else begin
      if (req_i[IDX_TX]) begin
        cause_o = CAUSE_TX;
        grant_o[IDX_TX] = 1'b1;
      end else if (req_i[IDX_RX]) begin
        cause_o = CAUSE_RX;
        grant_o[IDX_RX] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception controller: takes one event from user mode, redirects
// the PC to its vector and holds SERVICE until the handler's eret.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE    = VEC_BASE_DEFAULT,
  parameter int          TX_PRIO_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        cpu_stall,
  input  logic        timer_irq,
  input  logic        uart_rx_evt,
  input  logic        uart_tx_evt,
  input  logic        exc_req,
  input  logic        eret,
  output logic        take,
  output logic [31:0] vector_pc,
  output logic [31:0] epc_data,
  output logic [2:0]  cause,
  output logic        in_service,
  output logic        nest_err
);

  state_e     state_q, state_d;
  logic [2:0] cause_q, cause_d;
  logic       rx_pend_q, rx_pend_d;
  logic       tx_pend_q, tx_pend_d;
  logic       nest_err_q, nest_err_d;

  logic [3:0] req;
  logic [3:0] grant;
  logic [2:0] enc_cause;
  logic       take_ok;

  // A pulse arriving in the same cycle is a request right away.
  assign req[IDX_EXC]   = exc_req;
  assign req[IDX_TIMER] = timer_irq;
  assign req[IDX_RX]    = rx_pend_q | uart_rx_evt;
  assign req[IDX_TX]    = tx_pend_q | uart_tx_evt;

  irq_prio_enc #(
    .TX_PRIO_LOW(TX_PRIO_LOW)
  ) u_enc (
    .req_i   (req),
    .cause_o (enc_cause),
    .grant_o (grant)
  );

  assign take_ok = (state_q == ST_IDLE) && !pc[31] && !cpu_stall && (|grant);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    rx_pend_d  = rx_pend_q | uart_rx_evt;
    tx_pend_d  = tx_pend_q | uart_tx_evt;
    nest_err_d = nest_err_q | (exc_req && (pc[31] || (state_q == ST_SERVICE)));
    case (state_q)
      ST_IDLE: begin
        if (take_ok) begin
          state_d = ST_SERVICE;
          cause_d = enc_cause;
          // Servicing consumes one event; an older pending one plus a new pulse leaves one behind.
          if (grant[IDX_RX]) rx_pend_d = rx_pend_q & uart_rx_evt;
          if (grant[IDX_TX]) tx_pend_d = tx_pend_q & uart_tx_evt;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      rx_pend_q  <= 1'b0;
      tx_pend_q  <= 1'b0;
      nest_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      rx_pend_q  <= rx_pend_d;
      tx_pend_q  <= tx_pend_d;
      nest_err_q <= nest_err_d;
    end
  end

  // take is gated by reset so it drops immediately, not at the next edge.
  assign take       = take_ok && !reset;
  assign vector_pc  = take ? (VEC_BASE | {vec_word(enc_cause), 2'b00}) : 32'd0;
  assign epc_data   = take ? (grant[IDX_EXC] ? pc + 32'd4 : pc) : 32'd0;
  assign cause      = take ? enc_cause : cause_q;
  assign in_service = (state_q == ST_SERVICE);
  assign nest_err   = nest_err_q;

endmodule
